// File: rtl/decode_queue.sv
// Decode-and-buffer stage between fetch and issue: decodes raw words into instruction
// packages and queues them in a DEPTH-entry FIFO. Optional counters: DECODE_QUEUE_STATS_EN.
module decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_word,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2:0]                 out_kind,
    output logic [2:0]                 out_cond,
    output logic [4:0]                 out_op,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_rs,
    output logic [4:0]                 out_rq,
    output logic [XLEN-1:0]            out_imm,
    output logic [1:0]                 out_shift_type,
    output logic [4:0]                 out_shift_amt,
    output logic [XLEN-1:0]            out_pc,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef DECODE_QUEUE_STATS_EN
    ,
    output logic [15:0]                illegal_cnt,
    output logic [15:0]                flushed_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    localparam logic [2:0] KIND_RRR     = 3'd0;
    localparam logic [2:0] KIND_MEMORY  = 3'd1;
    localparam logic [2:0] KIND_MODEL   = 3'd2;
    localparam logic [2:0] KIND_RRI     = 3'd3;
    localparam logic [2:0] KIND_CUSTOM  = 3'd4;
    localparam logic [2:0] KIND_INVALID = 3'd7;
    localparam logic [4:0] BINOP_CMP    = 5'd16;
    localparam logic [4:0] MEMOP_RR_MAX = 5'd5;
    localparam logic [4:0] MEMOP_RI_MAX = 5'd11;

    typedef struct packed {
        logic [2:0]      kind;
        logic [2:0]      cond;
        logic [4:0]      op;
        logic [4:0]      rd;
        logic [4:0]      rs;
        logic [4:0]      rq;
        logic [XLEN-1:0] imm;
        logic [1:0]      shift_type;
        logic [4:0]      shift_amt;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } entry_t;

    entry_t          dec;
    entry_t          head;
    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            full, empty, push, pop;
    logic [XLEN-1:0] imm_s, imm_z;

    assign imm_s = {{(XLEN-11){in_word[10]}}, in_word[10:0]};
    assign imm_z = {{(XLEN-26){1'b0}}, in_word[25:0]};

    always_comb begin
        dec      = '0;
        dec.pc   = in_pc;
        dec.kind = in_word[31:29];
        dec.cond = in_word[28:26];
        dec.op   = in_word[25:21];
        dec.rd   = in_word[20:16];
        dec.rs   = in_word[15:11];
        case (in_word[31:29])
            KIND_RRR: begin
                dec.rq         = in_word[10:6];
                dec.shift_type = in_word[5:4];
                dec.shift_amt  = {1'b0, in_word[3:0]};
                dec.illegal    = in_word[25:21] > BINOP_CMP;
            end
            KIND_RRI: begin
                dec.imm     = imm_s;
                dec.illegal = in_word[25:21] > BINOP_CMP;
            end
            KIND_MEMORY: begin
                if (in_word[25:21] <= MEMOP_RR_MAX)      dec.rq  = in_word[10:6];
                else if (in_word[25:21] <= MEMOP_RI_MAX) dec.imm = imm_s;
                else                                     dec.illegal = 1'b1;
            end
            KIND_MODEL, KIND_CUSTOM: begin
                dec.op  = '0;
                dec.rd  = '0;
                dec.rs  = '0;
                dec.imm = imm_z;
            end
            default: begin
                // Undefined kinds still carry their PC so issue can raise the exception.
                dec.kind    = KIND_INVALID;
                dec.cond    = '0;
                dec.op      = '0;
                dec.rd      = '0;
                dec.rs      = '0;
                dec.illegal = 1'b1;
            end
        endcase
    end

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full && !flush;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dec;
    end

    // Data fields read as zero whenever nothing is queued.
    assign head           = out_valid ? mem[rd_ptr] : '0;
    assign out_kind       = head.kind;
    assign out_cond       = head.cond;
    assign out_op         = head.op;
    assign out_rd         = head.rd;
    assign out_rs         = head.rs;
    assign out_rq         = head.rq;
    assign out_imm        = head.imm;
    assign out_shift_type = head.shift_type;
    assign out_shift_amt  = head.shift_amt;
    assign out_pc         = head.pc;
    assign out_illegal    = head.illegal;

`ifdef DECODE_QUEUE_STATS_EN
    logic [16:0] flushed_sum;
    assign flushed_sum = {1'b0, flushed_cnt} + 17'(count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
            flushed_cnt <= '0;
        end else begin
            if (push && dec.illegal && illegal_cnt != 16'hFFFF)
                illegal_cnt <= illegal_cnt + 1'b1;
            if (flush)
                flushed_cnt <= flushed_sum[16] ? 16'hFFFF : flushed_sum[15:0];
        end
    end
`endif
endmodule
